// File: rtl/stage_pkg.sv
// stage_pkg: shared types and constants for the stage-2 quiz and its stage-3 consumer.
//   state_t   : quiz FSM states
//   LFSR_INIT : reset / zero-seed substitute value of the key LFSR
//   LFSR_TAPS : feedback taps (bits 7,5,4,3) of the 8-bit Fibonacci LFSR
//   BONUS_W / LUCK_W : result widths shared with stage 3
//   calc_bonus: saturating bonus above the pass threshold
package stage_pkg;

  localparam int unsigned LFSR_W    = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ANS_W     = 3;
  localparam int unsigned BONUS_W   = 2;
  localparam int unsigned LUCK_W    = 3;
  localparam int unsigned BONUS_MAX = 3;

  localparam logic [LFSR_W-1:0] LFSR_INIT = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUIZ  = 2'd1,
    JUDGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // min(BONUS_MAX, ok - th); zero when below threshold so the subtraction never wraps
  function automatic logic [BONUS_W-1:0] calc_bonus(input logic [CNT_W-1:0] ok,
                                                    input logic [CNT_W-1:0] th);
    logic [CNT_W-1:0] diff;
    diff = ok - th;
    if (ok < th) begin
      return '0;
    end
    if (diff > CNT_W'(BONUS_MAX)) begin
      return BONUS_W'(BONUS_MAX);
    end
    return diff[BONUS_W-1:0];
  endfunction

endpackage

// File: rtl/stage2_quiz_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR producing the quiz key stream.
//   clk, rst : clock and synchronous active-high reset (reloads LFSR_INIT)
//   load     : load seed (a zero seed is replaced by LFSR_INIT to avoid lockup)
//   seed     : seed value
//   step     : shift one position, feedback = xor of tapped bits
//   value    : current register contents
module lfsr8
  import stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  logic fb_c;

  assign fb_c = ^(value & LFSR_TAPS);

  // load has priority over step; all-zero state would never leave zero
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= LFSR_INIT;
    end else if (load) begin
      value <= (seed == '0) ? LFSR_INIT : seed;
    end else if (step) begin
      value <= {value[LFSR_W-2:0], fb_c};
    end
  end

endmodule

// File: rtl/stage2_quiz.sv
// stage2_quiz: timed quiz of NUM_Q answers checked against an LFSR key stream.
// Optional feature macro: STAGE2_TIMEOUT_EN (per-question idle timeout of TIMEOUT cycles).
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a quiz (IDLE only); pass1 and seed sampled with it
//   ans_valid  : answer present; ans is the 3-bit answer
//   ans_ready  : high only in QUIZ
//   busy       : high whenever not IDLE
//   done       : one-cycle pulse, results valid
//   pass2, bonus2, luck3 : results to stage 3, held until the next judge
module stage2_quiz
  import stage_pkg::*;
#(
  parameter int unsigned NUM_Q   = 8,
  parameter int unsigned PASS_TH = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pass1,
  input  logic [LFSR_W-1:0]  seed,
  input  logic               ans_valid,
  input  logic [ANS_W-1:0]   ans,
  output logic               ans_ready,
  output logic               busy,
  output logic               done,
  output logic               pass2,
  output logic [BONUS_W-1:0] bonus2,
  output logic [LUCK_W-1:0]  luck3
);

  state_t            state;
  logic              p1_q;
  logic [CNT_W-1:0]  q_cnt;
  logic [CNT_W-1:0]  ok_cnt;
  logic [LFSR_W-1:0] lfsr;

  logic accept_c;
  logic tmo_c;
  logic advance_c;
  logic last_c;
  logic correct_c;
  logic pass_c;
  logic load_c;

  // ans_ready is a registered copy of (state == QUIZ)
  assign accept_c  = ans_valid && ans_ready;
  assign advance_c = accept_c || tmo_c;
  assign last_c    = (q_cnt == CNT_W'(NUM_Q - 1));
  assign correct_c = (ans == lfsr[ANS_W-1:0]);
  assign pass_c    = p1_q && (ok_cnt >= CNT_W'(PASS_TH));
  assign load_c    = (state == IDLE) && start;

`ifdef STAGE2_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt;

  // fires on the TIMEOUT-th consecutive quiz cycle without an accept
  assign tmo_c = (state == QUIZ) && !accept_c && (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state != QUIZ) || accept_c || tmo_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  // no timeout: the quiz waits for answers indefinitely
  assign tmo_c = 1'b0 && (TIMEOUT != 0);
`endif

  lfsr8 u_lfsr8 (
    .clk   (clk),
    .rst   (rst),
    .load  (load_c),
    .seed  (seed),
    .step  ((state == QUIZ) && advance_c),
    .value (lfsr)
  );

  // quiz FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p1_q      <= 1'b0;
      q_cnt     <= '0;
      ok_cnt    <= '0;
      ans_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass2     <= 1'b0;
      bonus2    <= '0;
      luck3     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            p1_q      <= pass1;
            q_cnt     <= '0;
            ok_cnt    <= '0;
            ans_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= QUIZ;
          end
        end
        QUIZ: begin
          if (advance_c) begin
            q_cnt <= q_cnt + CNT_W'(1);
            // a timed-out question is never counted as correct
            if (accept_c && correct_c) begin
              ok_cnt <= ok_cnt + CNT_W'(1);
            end
            if (last_c) begin
              ans_ready <= 1'b0;
              state     <= JUDGE;
            end
          end
        end
        JUDGE: begin
          pass2  <= pass_c;
          bonus2 <= pass_c ? calc_bonus(ok_cnt, CNT_W'(PASS_TH)) : '0;
          luck3  <= lfsr[LUCK_W-1:0];
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stage2_quiz.md
Name: stage2_quiz

Overview:
- Sequential stage directly upstream of the stage-3 evaluator.
- Runs a timed quiz of NUM_Q answers against an LFSR-generated key stream and counts correct answers.
- Produces pass2, bonus2[1:0] and luck3[2:0]; stage 3 consumes all three.
- Gated by pass1 from stage 1, which is sampled at start.

Parameters:
- NUM_Q, 8: number of questions per quiz, range 2..15.
- PASS_TH, 5: minimum correct answers for pass2, range 1..NUM_Q.
- TIMEOUT, 15: idle cycles allowed per question; used only with STAGE2_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin quiz; honoured only in IDLE.
- pass1  in  1  stage-1 result; sampled on the start cycle.
- seed  in  8  LFSR seed; sampled on the start cycle.
- ans_valid  in  1  answer present.
- ans  in  3  answer value.
- ans_ready  out  1  stage accepts an answer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results are valid.
- pass2  out  1  stage-2 pass; to stage 3.
- bonus2  out  2  stage-2 bonus 0..3; to stage 3.
- luck3  out  3  luck value; to stage 3.

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE, from any state including mid-quiz. Every output goes to 0, all counters clear, LFSR is loaded with 8'hA5.
- FSM states: IDLE, QUIZ, JUDGE, DONE.
  - IDLE: on start=1, latch pass1 into p1_q. Load LFSR with seed, or 8'hA5 if seed==0 (lockup guard). Clear q_cnt and ok_cnt; go to QUIZ.
  - In IDLE, start=0 and any ans_valid are ignored.
  - QUIZ: ans_ready=1. Accept = ans_valid && ans_ready.
    - On accept: key = lfsr[2:0] (pre-step value). If ans==key, ok_cnt += 1.
    - Also on accept: q_cnt += 1, and the LFSR steps.
    - LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
    - When the accept that makes q_cnt==NUM_Q occurs, go to JUDGE.
  - JUDGE: one cycle; ans_ready=0. Register results, then go to DONE.
    - pass2 = p1_q && (ok_cnt >= PASS_TH).
    - bonus2 = pass2 ? min(3, ok_cnt - PASS_TH) : 0.
    - luck3 = lfsr[2:0], i.e. after NUM_Q steps.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Outputs: pass2, bonus2 and luck3 hold their values in IDLE until the next JUDGE. They are not cleared by start.
- Latency: final accept at cycle t, JUDGE at t+1, done=1 with valid results at t+2. Earliest start acceptance is t+3.
- Arithmetic: q_cnt and ok_cnt are 4 bits wide; ok_cnt never exceeds NUM_Q. The subtraction for bonus2 is evaluated only when ok_cnt >= PASS_TH, so it never underflows.
- Boundary conditions:
  - start while busy: ignored.
  - ans_valid held high continuously: one answer accepted per cycle.
  - pass1=0: the quiz runs normally, but pass2=0, bonus2=0 and luck3 is still produced.
  - seed==0: substituted with 8'hA5.
  - ans_ready is never high outside QUIZ.
  - rst asserted in the same cycle as start or as an accept: rst wins.

Optional Feature:
- Macro: STAGE2_TIMEOUT_EN.
- With the macro defined:
  - A per-question idle counter, 4 bits wide, increments on each QUIZ cycle with no accept.
  - When it reaches TIMEOUT, the current question is forced wrong: q_cnt += 1, LFSR steps, ok_cnt is unchanged, and the counter clears.
  - The counter also clears on every accept.
  - A timeout on the last question leads to JUDGE, exactly like an accept.
- Without the macro: the counter does not exist and QUIZ waits indefinitely.

Decomposition:
- Package stage_pkg holds:
  - state enum {IDLE, QUIZ, JUDGE, DONE};
  - LFSR_INIT = 8'hA5;
  - the LFSR tap mask;
  - bonus width 2 and luck width 3, shared with stage 3.
- One sub-module, lfsr8: 8-bit Fibonacci LFSR. Inputs: load, seed, step. Output: the lfsr value. It contains the zero-seed guard.

Test Plan:
- Seed 8'h01, pass1=1, all 8 answers equal the model key -> done at t+2, pass2=1, bonus2=3, luck3 = model lfsr[2:0] after 8 steps.
- Seed 8'h3C, pass1=1, exactly 5 answers correct -> pass2=1, bonus2=0. Exactly 4 correct -> pass2=0, bonus2=0.
- pass1=0 and all answers correct -> pass2=0, bonus2=0, done pulses once; seed=0 gives the same key stream as seed=8'hA5.
- rst pulsed after the 3rd accept, then a new start -> outputs are 0 after reset and the new quiz needs a full 8 answers; start pulsed during QUIZ has no effect.
- ans_valid toggling 1,0,1 with gaps -> only cycles with ans_valid=1 in QUIZ count; ans_ready=0 in JUDGE and DONE.
- STAGE2_TIMEOUT_EN defined, TIMEOUT=15, no answers driven -> q_cnt advances every 15 cycles, JUDGE after 120 QUIZ cycles, pass2=0.
